la_rstseq: RTL and testbench

- Reset sequencer for multi-domain designs. It takes one synchronized reset and releases N active-low domain resets one at a time, in a fixed order, with programmable spacing.
- It sits downstream of the per-clock reset synchronizers, one instance per clock domain tree.
- It drives the nrst inputs of the domain logic and re-runs the full sequence on a software request.

---
 rtl/la_rstseq_pkg.sv | 9 +
 rtl/la_rstseq_cnt.sv | 26 ++
 rtl/la_rstseq.sv | 90 +++++++++
 tb/tb_la_rstseq.sv | 106 ++++++++++
 4 files changed

// File: rtl/la_rstseq_pkg.sv
// la_rstseq_pkg: shared state encoding for the reset sequencer.
package la_rstseq_pkg;
  localparam int SW = 2;
  typedef enum logic [SW-1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/la_rstseq_cnt.sv
// la_rstseq_cnt: dwell counter with terminal compare against HOLD (ASSERT) or DELAY (RELEASE).
module la_rstseq_cnt
  import la_rstseq_pkg::*;
#(
  parameter int CW    = 8,
  parameter int HOLD  = 8,
  parameter int DELAY = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   restart_i,
  input  state_e state_i,
  output logic   tc_o
);
  if ((2 ** CW) <= HOLD || (2 ** CW) <= DELAY) begin : g_cw_chk
    $error("la_rstseq_cnt: CW too small for HOLD/DELAY");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  // a restart edge is itself edge 0 of the new dwell, so it loads 1 rather than 0
  always_comb cnt_d = restart_i ? CW'(1) : (state_i == DONE ? cnt_q : cnt_q + 1'b1);
  assign tc_o = cnt_q == (state_i == RELEASE ? CW'(DELAY) : CW'(HOLD));
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/la_rstseq.sv
// la_rstseq: releases N active-low domain resets in order after HOLD cycles, DELAY apart.
module la_rstseq
  import la_rstseq_pkg::*;
#(
  parameter int N     = 4,
  parameter int HOLD  = 8,
  parameter int DELAY = 16,
  parameter int CW    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  output logic [N-1:0] nrst_out,
  output logic         busy,
  output logic         done
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0] nrst_q, nrst_d;
  logic busy_q, done_q, done_d, restart, tc;
  la_rstseq_cnt #(.CW(CW), .HOLD(HOLD), .DELAY(DELAY)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .state_i   (state_q),
    .tc_o      (tc)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nrst_d  = nrst_q;
    done_d  = done_q;
    restart = 1'b0;
    case (state_q)
      ASSERT: begin
        restart = req | tc;
        if (!req && tc) begin
          nrst_d  = N'(1);
          state_d = (N == 1) ? DONE : RELEASE;
          done_d  = (N == 1);
        end
      end
      RELEASE: begin
        restart = req | tc;
        if (req) begin
          nrst_d  = '0;
          idx_d   = '0;
          state_d = ASSERT;
        end else if (tc) begin
          // thermometer shift keeps lower domains released
          nrst_d = (nrst_q << 1) | N'(1);
          idx_d  = idx_q + 1'b1;
          if (idx_d == IW'(N - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        restart = req;
        if (req) begin
          nrst_d  = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          state_d = ASSERT;
        end
      end
      default: state_d = ASSERT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ASSERT;
      idx_q   <= '0;
      nrst_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nrst_q  <= nrst_d;
      busy_q  <= !done_d;
      done_q  <= done_d;
    end
  end
  assign nrst_out = nrst_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_la_rstseq.sv
// tb_la_rstseq: three parameterisations driven together, checked against an edge-count model.
module tb_la_rstseq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic [3:0] n0;
  logic [0:0] n1;
  logic [2:0] n2;
  logic b0, b1, b2, d0, d1, d2;
  int checks = 0;
  int failures = 0;
  int ed[3];
  always #5 clk = ~clk;
  la_rstseq #(.N(4), .HOLD(8), .DELAY(16), .CW(8)) dut0 (
    .clk(clk), .rst(rst), .req(req), .nrst_out(n0), .busy(b0), .done(d0));
  la_rstseq #(.N(1), .HOLD(1), .DELAY(1), .CW(2)) dut1 (
    .clk(clk), .rst(rst), .req(req), .nrst_out(n1), .busy(b1), .done(d1));
  la_rstseq #(.N(3), .HOLD(3), .DELAY(1), .CW(4)) dut2 (
    .clk(clk), .rst(rst), .req(req), .nrst_out(n2), .busy(b2), .done(d2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // domains released e edges into a sequence: first at HOLD, then one every DELAY
  function automatic int rel(input int e, input int n, input int h, input int d);
    int k;
    if (e < h) return 0;
    k = (e - h) / d + 1;
    return k > n ? n : k;
  endfunction
  function automatic logic [31:0] therm(input int k);
    return (32'd1 << k) - 32'd1;
  endfunction
  task automatic check_one(input string tag, input logic [31:0] n, input logic b, input logic d,
                           input int e, input int nn, input int h, input int dl);
    int k;
    k = rel(e, nn, h, dl);
    chk({tag, "_nrst"}, n, therm(k));
    chk({tag, "_busy"}, 32'(b), 32'(k < nn));
    chk({tag, "_done"}, 32'(d), 32'(k == nn));
    chk({tag, "_therm"}, 32'((n & (n + 32'd1)) == 32'd0), 32'd1);
    chk({tag, "_busy_ndone"}, 32'(b), 32'(!d));
  endtask
  task automatic step(input logic r, input logic q);
    rst = r;
    req = q;
    @(posedge clk);
    for (int i = 0; i < 3; i++) ed[i] = r ? -1 : q ? 0 : (ed[i] < 1000 ? ed[i] + 1 : ed[i]);
    #1;
    check_one("d0", 32'(n0), b0, d0, ed[0], 4, 8, 16);
    check_one("d1", 32'(n1), b1, d1, ed[1], 1, 1, 1);
    check_one("d2", 32'(n2), b2, d2, ed[2], 3, 3, 1);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) ed[i] = -1;
    repeat (5) step(1'b1, 1'b0);
    for (int e = 0; e <= 56; e++) begin
      step(1'b0, 1'b0);
      if (e == 7) chk("plan_e7", 32'(n0), 32'h0);
      if (e == 8) chk("plan_e8", 32'(n0), 32'h1);
      if (e == 24) chk("plan_e24", 32'(n0), 32'h3);
      if (e == 40) chk("plan_e40", 32'(n0), 32'h7);
      if (e == 56) chk("plan_e56", 32'({n0, d0, b0}), 32'h3e);
    end
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("req_done_clear", 32'({n0, b0, d0}), 32'h2);
    for (int e = 1; e <= 57; e++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int e = 1; e <= 29; e++) step(1'b0, 1'b0);
    chk("pre_abort", 32'(n0), 32'h3);
    step(1'b0, 1'b1);
    chk("abort_e30", 32'(n0), 32'h0);
    for (int e = 31; e <= 86; e++) begin
      step(1'b0, 1'b0);
      if (e == 38) chk("abort_e38", 32'(n0), 32'h1);
      if (e == 86) chk("abort_e86", 32'(n0), 32'hf);
    end
    step(1'b0, 1'b1);
    for (int e = 1; e <= 44; e++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_wins", 32'({n0, b0, d0}), 32'h2);
    step(1'b1, 1'b0);
    for (int e = 0; e <= 10; e++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int e = 3; e <= 12; e++) step(1'b0, 1'b1);
    for (int e = 13; e <= 70; e++) begin
      step(1'b0, 1'b0);
      if (e == 19) chk("held_e19", 32'(n0), 32'h0);
      if (e == 20) chk("held_e20", 32'(n0), 32'h1);
      if (e == 68) chk("held_e68", 32'(n0), 32'hf);
    end
    for (int i = 0; i < 800; i++) begin
      int pr;
      pr = (i / 200) % 2 == 0 ? 90 : 8;
      step($urandom_range(0, 63) == 0, $urandom_range(0, pr) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
